// File: rtl/uart_pkg.sv
// Shared UART types and defaults.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS     = 8;
  localparam int unsigned UART_RX_OVERSAMPLE = 32;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous single-bit inputs; reset value is configurable.
module uart_sync #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic arst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], d};
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detect, centre sampling, valid/ready byte output.
// Define UART_RX_PARITY_EN to add a parity bit (parity_mode/parity_err ports).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_RX_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 active,
  input  logic                 rx_clk_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_mode,
  output logic                 parity_err,
`endif
  output logic                 rx_busy
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS);

  localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state_q, state_d;
  logic [TickW-1:0]     tick_q, tick_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 oerr_q, oerr_d;
  logic                 deliver;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q, par_bit_d;
  logic                 perr_q, perr_d;
`endif

  uart_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk   (clk),
    .arst_n(arst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ferr_d  = 1'b0;
    deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
    perr_d    = 1'b0;
`endif

    if (!active) begin
      state_d = RX_IDLE;
      tick_d  = '0;
      bit_d   = '0;
      shreg_d = '0;
    end else if (rx_clk_en) begin
      unique case (state_q)
        RX_IDLE: begin
          if (!rx_s) begin
            state_d = RX_START;
            tick_d  = '0;
          end
        end
        RX_START: begin
          if (tick_q == TickHalf) begin
            // Line back high at start-bit centre: treat as a glitch.
            state_d = rx_s ? RX_IDLE : RX_DATA;
            tick_d  = '0;
            bit_d   = '0;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
        RX_DATA: begin
          if (tick_q == TickLast) begin
            tick_d  = '0;
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (bit_q == BitLast) begin
              bit_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = RX_PARITY;
`else
              state_d = RX_STOP;
`endif
            end else begin
              bit_d = bit_q + BitW'(1);
            end
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
        RX_PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (tick_q == TickLast) begin
            tick_d    = '0;
            par_bit_d = rx_s;
            state_d   = RX_STOP;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
`else
          state_d = RX_IDLE;
`endif
        end
        RX_STOP: begin
          if (tick_q == TickLast) begin
            // Return to idle at stop centre so a following start edge is not missed.
            state_d = RX_IDLE;
            tick_d  = '0;
            deliver = rx_s;
            ferr_d  = !rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d = ((^shreg_q) ^ par_bit_q) != parity_mode;
`endif
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end

    data_d  = data_q;
    valid_d = valid_q;
    oerr_d  = 1'b0;
    if (deliver) begin
      if (!valid_q || rx_ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        oerr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= RX_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      oerr_q    <= oerr_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;
  assign rx_busy     = (state_q != RX_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q;
`endif

endmodule
